// File: rtl/btn_arbiter_if.sv
// Button-arbiter bus: raw button levels and enable in, one-hot grant pulse,
// grant index and status flags out.
interface btn_arbiter_if #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]  btn;
    logic          enable;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          grant_valid;
    logic          busy;
    logic          dropped;

    modport master (
        output btn, enable,
        input  grant, grant_idx, grant_valid, busy, dropped
    );

    modport slave (
        input  btn, enable,
        output grant, grant_idx, grant_valid, busy, dropped
    );
endinterface

// File: rtl/btn_arbiter.sv
// Round-robin arbiter granting one synchronized button press per grant cycle,
// followed by a cooldown lockout. Optional macro BTN_ARB_PENDING_EN remembers un-served presses.
module btn_arbiter #(
    parameter int N        = 2,
    parameter int COOLDOWN = 4,
    parameter int IW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clock,
    input  logic         reset,
    btn_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    localparam logic [7:0]    CD_INIT  = 8'(COOLDOWN);
    localparam logic [IW-1:0] PTR_INIT = IW'(N - 1);

    // Returns {found, index} of the first set candidate after ptr, wrapping.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0] cand, input logic [IW-1:0] ptr);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!res[IW] && cand[idx]) begin
                res = {1'b1, IW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [N-1:0]  sync1_r, sync2_r, prev_r;
    logic [N-1:0]  rise_s, cand_s, win_onehot_s;
    state_t        state_r, next_state_s;
    logic [7:0]    cnt_r, cnt_next_s;
    logic [IW-1:0] ptr_r, win_idx_s;
    logic [IW:0]   pick_s;
    logic          arb_ok_s, do_grant_s, drop_s;
    logic [N-1:0]  grant_r;
    logic [IW-1:0] grant_idx_r;
    logic          grant_valid_r, busy_r, dropped_r;

    assign rise_s = sync2_r & ~prev_r;

`ifdef BTN_ARB_PENDING_EN
    logic [N-1:0] pending_r;
    assign cand_s = rise_s | pending_r;
    // A repeat press on a bit still waiting for service is the only loss.
    assign drop_s = bus.enable & (|(rise_s & pending_r));

    // Pending presses accumulate until granted; disabling flushes them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_r <= '0;
        end else if (!bus.enable) begin
            pending_r <= '0;
        end else begin
            pending_r <= (pending_r | rise_s) & ~win_onehot_s;
        end
    end
`else
    assign cand_s = rise_s;
    assign drop_s = bus.enable & (|(rise_s & ~win_onehot_s));
`endif

    // Arbitration and next-state selection.
    always_comb begin
        arb_ok_s     = 1'b0;
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        win_onehot_s = '0;
        pick_s       = rr_pick(cand_s, ptr_r);
        win_idx_s    = pick_s[IW-1:0];
        case (state_r)
            ST_IDLE:     arb_ok_s = 1'b1;
            ST_GRANT:    arb_ok_s = (COOLDOWN == 0);
            ST_COOLDOWN: arb_ok_s = 1'b0;
            default:     arb_ok_s = 1'b0;
        endcase
        do_grant_s = arb_ok_s & bus.enable & pick_s[IW];
        if (do_grant_s) begin
            win_onehot_s[win_idx_s] = 1'b1;
        end else begin
            win_onehot_s = '0;
        end
        case (state_r)
            ST_IDLE: begin
                if (do_grant_s) begin
                    next_state_s = ST_GRANT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (COOLDOWN > 0) begin
                    next_state_s = ST_COOLDOWN;
                    cnt_next_s   = CD_INIT;
                end else if (do_grant_s) begin
                    next_state_s = ST_GRANT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_COOLDOWN: begin
                if (cnt_r <= 8'd1) begin
                    next_state_s = ST_IDLE;
                    cnt_next_s   = 8'd0;
                end else begin
                    cnt_next_s = cnt_r - 8'd1;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = 8'd0;
            end
        endcase
    end

    // Synchronizer, edge detector, FSM state and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r       <= '0;
            sync2_r       <= '0;
            prev_r        <= '0;
            state_r       <= ST_IDLE;
            cnt_r         <= 8'd0;
            ptr_r         <= PTR_INIT;
            grant_r       <= '0;
            grant_idx_r   <= '0;
            grant_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            dropped_r     <= 1'b0;
        end else begin
            sync1_r       <= bus.btn;
            sync2_r       <= sync1_r;
            prev_r        <= sync2_r;
            state_r       <= next_state_s;
            cnt_r         <= cnt_next_s;
            ptr_r         <= do_grant_s ? win_idx_s : ptr_r;
            grant_r       <= win_onehot_s;
            grant_idx_r   <= do_grant_s ? win_idx_s : '0;
            grant_valid_r <= do_grant_s;
            busy_r        <= (next_state_s == ST_COOLDOWN);
            dropped_r     <= drop_s;
        end
    end

    assign bus.grant       = grant_r;
    assign bus.grant_idx   = grant_idx_r;
    assign bus.grant_valid = grant_valid_r;
    assign bus.busy        = busy_r;
    assign bus.dropped     = dropped_r;
endmodule

// File: tb/tb_btn_arbiter.sv
// Scoreboard bench for btn_arbiter: DUT A (COOLDOWN=4) and DUT B (COOLDOWN=0).
module tb_btn_arbiter;
    localparam int N  = 2;
    localparam int IW = 1;

    typedef struct {
        int           cyc;
        logic [N-1:0] grant;
        logic [IW-1:0] idx;
        logic         dropped;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    int   busy_a[$];
    int   busy_b[$];

    btn_arbiter_if #(.N(N), .IW(IW)) bus_a ();
    btn_arbiter_if #(.N(N), .IW(IW)) bus_b ();

    btn_arbiter #(.N(N), .COOLDOWN(4), .IW(IW)) u_dut_a (.clock(clock), .reset(reset), .bus(bus_a.slave));
    btn_arbiter #(.N(N), .COOLDOWN(0), .IW(IW)) u_dut_b (.clock(clock), .reset(reset), .bus(bus_b.slave));

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mon_event(input string tag, input bit have, input exp_t e, input logic [N-1:0] g,
                             input logic [IW-1:0] idx, input logic v, input logic d);
        if (!have) begin
            check({tag, "_unexpected_output"}, int'({g, v, d}), 0);
        end else begin
            check({tag, "_cycle"}, cyc, e.cyc);
            check({tag, "_grant"}, int'(g), int'(e.grant));
            check({tag, "_grant_idx"}, int'(idx), int'(e.idx));
            check({tag, "_grant_valid"}, int'(v), int'(|e.grant));
            check({tag, "_dropped"}, int'(d), int'(e.dropped));
        end
    endtask

    task automatic push_a(input int c, input logic [N-1:0] g, input logic [IW-1:0] i, input logic d);
        exp_t e;
        e.cyc = c; e.grant = g; e.idx = i; e.dropped = d;
        exp_a.push_back(e);
    endtask

    task automatic push_b(input int c, input logic [N-1:0] g, input logic [IW-1:0] i, input logic d);
        exp_t e;
        e.cyc = c; e.grant = g; e.idx = i; e.dropped = d;
        exp_b.push_back(e);
    endtask

    // Monitor: pops expectations whenever a DUT shows a grant/drop, and times busy windows.
    initial begin
        exp_t e;
        bit   have;
        int   bs_a = 0;
        int   bs_b = 0;
        logic bp_a = 1'b0;
        logic bp_b = 1'b0;
        forever begin
            @(negedge clock);
            if (bus_a.grant_valid || bus_a.dropped || bus_a.grant != '0) begin
                have = (exp_a.size() > 0);
                if (have) e = exp_a.pop_front();
                mon_event("a", have, e, bus_a.grant, bus_a.grant_idx, bus_a.grant_valid, bus_a.dropped);
            end
            if (bus_b.grant_valid || bus_b.dropped || bus_b.grant != '0) begin
                have = (exp_b.size() > 0);
                if (have) e = exp_b.pop_front();
                mon_event("b", have, e, bus_b.grant, bus_b.grant_idx, bus_b.grant_valid, bus_b.dropped);
            end
            if (bus_a.busy && !bp_a) bs_a = cyc;
            if (!bus_a.busy && bp_a) begin
                if (busy_a.size() > 0) check("a_busy_len", cyc - bs_a, busy_a.pop_front());
                else check("a_busy_unexpected", cyc - bs_a, 0);
            end
            if (bus_b.busy && !bp_b) bs_b = cyc;
            if (!bus_b.busy && bp_b) begin
                if (busy_b.size() > 0) check("b_busy_len", cyc - bs_b, busy_b.pop_front());
                else check("b_busy_unexpected", cyc - bs_b, 0);
            end
            bp_a = bus_a.busy;
            bp_b = bus_b.busy;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    // Directed stimulus; each push records the cycle the response must appear in.
    initial begin
        int t;
        bus_a.btn = 2'b01; bus_a.enable = 1'b1;
        bus_b.btn = 2'b00; bus_b.enable = 1'b1;

        // Reset with btn[0] held, then release: one grant three cycles later.
        step(4);
        check("reset_outputs_a", int'({bus_a.grant, bus_a.grant_idx, bus_a.grant_valid, bus_a.busy, bus_a.dropped}), 0);
        check("reset_outputs_b", int'({bus_b.grant, bus_b.grant_idx, bus_b.grant_valid, bus_b.busy, bus_b.dropped}), 0);
        reset = 1'b1;
        t = cyc;
        push_a(t + 3, 2'b01, 1'b0, 1'b0); busy_a.push_back(4);
        step(10);
        bus_a.btn = 2'b00;
        step(3);

        // Single long press on btn[1].
        bus_a.btn = 2'b10; t = cyc;
        push_a(t + 3, 2'b10, 1'b1, 1'b0); busy_a.push_back(4);
        step(6);
        bus_a.btn = 2'b00;
        step(6);

        // Simultaneous presses, twice: pointer rotates the winner.
        bus_a.btn = 2'b11; t = cyc;
        push_a(t + 3, 2'b01, 1'b0, 1'b1); busy_a.push_back(4);
        step(2); bus_a.btn = 2'b00; step(10);
        bus_a.btn = 2'b11; t = cyc;
        push_a(t + 3, 2'b10, 1'b1, 1'b1); busy_a.push_back(4);
        step(2); bus_a.btn = 2'b00; step(10);

        // Press btn[0] so its rise lands in the 2nd busy cycle.
        bus_a.btn = 2'b10; t = cyc;
        push_a(t + 3, 2'b10, 1'b1, 1'b0); busy_a.push_back(4);
`ifdef BTN_ARB_PENDING_EN
        push_a(t + 9, 2'b01, 1'b0, 1'b0); busy_a.push_back(4);
`else
        push_a(t + 6, 2'b00, 1'b0, 1'b1);
`endif
        step(2); bus_a.btn = 2'b00;
        step(1); bus_a.btn = 2'b01;
        step(8); bus_a.btn = 2'b00;
        step(8);

        // Press while disabled: nothing at all.
        bus_a.enable = 1'b0;
        bus_a.btn = 2'b10;
        step(6); bus_a.btn = 2'b00;
        step(3); bus_a.enable = 1'b1;
        step(3);

        // Reset during cooldown aborts busy; next press is served normally.
        bus_a.btn = 2'b01; t = cyc;
        push_a(t + 3, 2'b01, 1'b0, 1'b0); busy_a.push_back(2);
        step(5);
        reset = 1'b0; bus_a.btn = 2'b00;
        #1;
        check("reset_aborts_busy", int'(bus_a.busy), 0);
        step(2);
        reset = 1'b1;
        step(2);
        bus_a.btn = 2'b10; t = cyc;
        push_a(t + 3, 2'b10, 1'b1, 1'b0); busy_a.push_back(4);
        step(3); bus_a.btn = 2'b00;
        step(8);

        // COOLDOWN=0: staggered presses give back-to-back grants.
        bus_b.btn = 2'b01; t = cyc;
        push_b(t + 3, 2'b01, 1'b0, 1'b0);
        push_b(t + 4, 2'b10, 1'b1, 1'b0);
        step(1); bus_b.btn = 2'b11;
        step(4); bus_b.btn = 2'b00;
        step(6);

        check("a_queue_drained", exp_a.size(), 0);
        check("b_queue_drained", exp_b.size(), 0);
        check("a_busy_queue_drained", busy_a.size(), 0);
        check("b_busy_queue_drained", busy_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
